// File: rtl/switch_debounce4.sv
// rtl/switch_debounce4.sv - four-channel switch debouncer with rise/fall pulses
// Each line is synchronized, then accepted once it disagrees with the held level for STABLE_CNT cycles.
module switch_debounce4 #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sw_in,
  input  logic       en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic       any_change
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CNT - 1);

  logic [3:0]      s1_q, s1_d;
  logic [3:0]      s2_q, s2_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [3:0]      deb_q, deb_d;
  logic [3:0]      rise_q, rise_d;
  logic [3:0]      fall_q, fall_d;
  logic            any_change_q, any_change_d;

  always_comb begin
    s1_d   = sw_in;
    s2_d   = s1_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == LAST_CNT) begin
          // Disagreement has persisted long enough: take the new level.
          deb_d[i]  = s2_q[i];
          cnt_d[i]  = 8'd0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
    any_change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      cnt_q        <= '0;
      deb_q        <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      any_change_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      cnt_q        <= cnt_d;
      deb_q        <= deb_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      any_change_q <= any_change_d;
    end
  end

  assign a          = deb_q[0];
  assign b          = deb_q[1];
  assign c          = deb_q[2];
  assign d          = deb_q[3];
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_change = any_change_q;

endmodule

// File: tb/tb_switch_debounce4.sv
// tb/tb_switch_debounce4.sv - directed checks of switch_debounce4 at STABLE_CNT 4 and 1
module tb_switch_debounce4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] sw_in, sw_in1;
  logic       a, b, c, d, any_change;
  logic [3:0] rise, fall;
  logic       a1, b1, c1, d1, any_change1;
  logic [3:0] rise1, fall1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  switch_debounce4 #(.STABLE_CNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .en(en),
    .a(a), .b(b), .c(c), .d(d),
    .rise(rise), .fall(fall), .any_change(any_change)
  );

  switch_debounce4 #(.STABLE_CNT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in1), .en(en),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .rise(rise1), .fall(fall1), .any_change(any_change1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                         input logic [3:0] f, input logic any);
    chk({tag, ".lvl"}, {d, c, b, a}, lvl);
    chk({tag, ".rise"}, rise, r);
    chk({tag, ".fall"}, fall, f);
    chk({tag, ".any"}, {3'b0, any_change}, {3'b0, any});
  endtask

  task automatic chk1(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                      input logic [3:0] f);
    chk({tag, ".lvl1"}, {d1, c1, b1, a1}, lvl);
    chk({tag, ".rise1"}, rise1, r);
    chk({tag, ".fall1"}, fall1, f);
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    sw_in   = 4'b0000;
    sw_in1  = 4'b0000;
    tick(2);
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk1("reset", 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    en      = 1'b1;
    tick(2);

    // Basic accept: a appears on the 6th edge, pulse lasts one cycle.
    sw_in = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_all("basic_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(1);
    chk_all("basic_edge6", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    tick(1);
    chk_all("basic_edge7", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    sw_in = 4'b0000;
    tick(5);
    chk_all("basic_back_wait", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_all("basic_back", 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tick(1);

    // Three-cycle glitch on bit2 must vanish.
    sw_in = 4'b0100;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) sw_in = 4'b0000;
      tick(1);
      chk_all("glitch3", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Four-cycle pulse is accepted and later released.
    sw_in = 4'b0100;
    tick(4);
    sw_in = 4'b0000;
    tick(1);
    chk_all("pulse4_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_all("pulse4_up", 4'b0100, 4'b0100, 4'b0000, 1'b1);
    tick(3);
    chk_all("pulse4_hold", 4'b0100, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_all("pulse4_down", 4'b0000, 4'b0000, 4'b0100, 1'b1);
    tick(1);
    chk_all("pulse4_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Simultaneous flip of all four lines.
    sw_in = 4'b1111;
    tick(5);
    chk_all("simul_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_all("simul_up", 4'b1111, 4'b1111, 4'b0000, 1'b1);
    tick(1);
    chk_all("simul_after", 4'b1111, 4'b0000, 4'b0000, 1'b0);
    sw_in = 4'b0000;
    tick(6);
    chk_all("simul_down", 4'b0000, 4'b0000, 4'b1111, 1'b1);
    tick(1);

    // Enable freeze after two counting cycles.
    sw_in = 4'b1000;
    tick(4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("frozen", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    en = 1'b1;
    tick(1);
    chk_all("resume1", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_all("resume2", 4'b1000, 4'b1000, 4'b0000, 1'b1);
    tick(1);
    sw_in = 4'b0000;
    tick(6);
    chk_all("freeze_down", 4'b0000, 4'b0000, 4'b1000, 1'b1);
    tick(1);

    // Reset mid-count: a already high, b at cnt=3.
    sw_in = 4'b0001;
    tick(7);
    sw_in = 4'b0011;
    tick(5);
    chk_all("pre_reset", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    chk_all("post_reset_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_all("post_reset_up", 4'b0011, 4'b0011, 4'b0000, 1'b1);
    sw_in = 4'b0000;
    tick(8);

    // STABLE_CNT=1: two-cycle pulse, then one-cycle pulse.
    sw_in1 = 4'b0001;
    tick(2);
    sw_in1 = 4'b0000;
    chk1("sc1_wait", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk1("sc1_up", 4'b0001, 4'b0001, 4'b0000);
    tick(1);
    chk1("sc1_hold", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    chk1("sc1_down", 4'b0000, 4'b0000, 4'b0001);
    tick(1);
    chk1("sc1_idle", 4'b0000, 4'b0000, 4'b0000);
    sw_in1 = 4'b0010;
    tick(1);
    sw_in1 = 4'b0000;
    tick(2);
    chk1("sc1_short_up", 4'b0010, 4'b0010, 4'b0000);
    tick(1);
    chk1("sc1_short_down", 4'b0000, 4'b0000, 4'b0010);
    chk("sc1_any", {3'b0, any_change1}, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
